// File: rtl/asyncmem_initiator.sv
`default_nettype none
// ===========================================================================
// Module : asyncmem_initiator
// Clocked CPU-side initiator for the async RRq/WRq/OK/Ack memory handshake.
// Optional macro ASYNCMEM_TIMEOUT_EN adds a WAIT_OK timeout that reports rsp_err.
// Rev    : 1.0
// ===========================================================================
module asyncmem_initiator #(
  parameter int AW             = 20,
  parameter int DW             = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int BLANK_CYCLES   = 3,
  parameter int RECOVER_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          req_ready,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] Addr,
  output logic          RRq,
  output logic          WRq,
  output logic          Ack,
  inout  wire  [DW-1:0] Data,
  input  logic          OK
);

  // The strobe phase also flushes the synchroniser, so a stale OK still in
  // the pipeline from the previous access can never complete this one.
  localparam int STROBE_LEN = BLANK_CYCLES + SYNC_STAGES;
  localparam int CNT_A      = (STROBE_LEN > RECOVER_CYCLES) ? STROBE_LEN : RECOVER_CYCLES;
`ifdef ASYNCMEM_TIMEOUT_EN
  localparam int CNT_MAX    = (CNT_A > TIMEOUT_CYCLES) ? CNT_A : TIMEOUT_CYCLES;
`else
  localparam int CNT_MAX    = CNT_A;
`endif
  localparam int CW         = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_WAIT_OK = 3'd3,
    S_ACK     = 3'd4,
    S_RECOVER = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [DW-1:0]          wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic                   data_oe_q, data_oe_d;
  logic                   rrq_q, rrq_d;
  logic                   wrq_q, wrq_d;
  logic                   ack_q, ack_d;
  logic                   ready_q, ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]          rdata_q, rdata_d;
  logic [SYNC_STAGES-1:0] ok_sync_q, ok_sync_d;
  logic                   err_q, err_d;
  logic                   ok_synced;
  logic                   enter_ack;

  assign ok_synced = ok_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    data_oe_d   = data_oe_q;
    rrq_d       = rrq_q;
    wrq_d       = wrq_q;
    ack_d       = 1'b0;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    ok_sync_d   = {ok_sync_q[SYNC_STAGES-2:0], OK};
    err_d       = err_q;
    enter_ack   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          write_d   = req_write;
          data_oe_d = req_write;
          ready_d   = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        rrq_d   = ~write_q;
        wrq_d   = write_q;
        cnt_d   = '0;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == CW'(STROBE_LEN - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT_OK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_OK: begin
        if (ok_synced) begin
          if (!write_q) rdata_d = Data;
          err_d     = 1'b0;
          enter_ack = 1'b1;
        end
`ifdef ASYNCMEM_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_d     = 1'b1;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_ACK: begin
        data_oe_d = 1'b0;
        cnt_d     = '0;
        if (RECOVER_CYCLES == 0) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (cnt_q == CW'(RECOVER_CYCLES - 1)) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase

    if (enter_ack) begin
      rrq_d       = 1'b0;
      wrq_d       = 1'b0;
      ack_d       = 1'b1;
      rsp_valid_d = 1'b1;
      state_d     = S_ACK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      data_oe_q   <= 1'b0;
      rrq_q       <= 1'b0;
      wrq_q       <= 1'b0;
      ack_q       <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      ok_sync_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      data_oe_q   <= data_oe_d;
      rrq_q       <= rrq_d;
      wrq_q       <= wrq_d;
      ack_q       <= ack_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      ok_sync_q   <= ok_sync_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign Addr      = addr_q;
  assign RRq       = rrq_q;
  assign WRq       = wrq_q;
  assign Ack       = ack_q;
  assign Data      = data_oe_q ? wdata_q : {DW{1'bz}};
`ifdef ASYNCMEM_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_asyncmem_initiator.sv
`default_nettype none
// Directed bench for asyncmem_initiator with a small behavioural async memory.
module tb_asyncmem_initiator;
  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] Addr;
  logic          RRq, WRq, Ack;
  wire  [DW-1:0] Data;
  logic          ok_drv;

  asyncmem_initiator dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Addr(Addr), .RRq(RRq), .WRq(WRq), .Ack(Ack), .Data(Data), .OK(ok_drv)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Memory: raises OK mem_delay cycles into a strobe, drives read data only while OK.
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] mem_rd = '0;
  logic [DW-1:0] wr_seen = '0;
  bit            mem_en = 1'b1;
  bit            ok_drop = 1'b1;
  int            mem_delay = 2;
  int            age = 0;

  assign Data = (RRq && ok_drv) ? mem_rd : {DW{1'bz}};

  initial begin
    ok_drv = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (RRq || WRq) age++; else age = 0;
      if (!mem_en) ok_drv = 1'b0;
      else if (age == mem_delay) begin
        if (WRq) begin mem[Addr] = Data; wr_seen = Data; end
        else mem_rd = mem[Addr];
        ok_drv = 1'b1;
      end
      if (Ack && ok_drop) ok_drv = 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            acc_cnt = 0, last_acc_cyc = 0, rsp_cnt = 0, rrq_rise_cyc = 0, both_strobe = 0;
  logic          rrq_prev = 1'b0;
  logic [AW-1:0] addr_at_rrq = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (req_valid && req_ready && rst_n) begin acc_cnt++; last_acc_cyc = cyc + 1; end
      if (RRq && !rrq_prev) begin rrq_rise_cyc = cyc; addr_at_rrq = Addr; end
      rrq_prev = RRq;
      if (rsp_valid) rsp_cnt++;
      if (RRq && WRq) both_strobe++;
    end
  end

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("accept_wait", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output bit found, output int lat);
    found = 1'b0;
    lat   = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid) begin found = 1'b1; lat = cyc - last_acc_cyc; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int lat, a0, t1, r0, n;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem[20'h00010] = 16'hBEEF;
    mem[20'hFFFFF] = 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_strobes",   32'({RRq, WRq, Ack}), 32'd0);
    chk("rst_addr",      32'(Addr),      32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Read 0x00010: OK one cycle after RRq, 7 cycles accept->rsp.
    issue(1'b0, 20'h00010, '0);
    wait_rsp(50, found, lat);
    chk("rd1_found",   32'(found),      32'd1);
    chk("rd1_latency", 32'(lat),        32'd7);
    chk("rd1_rdata",   32'(rsp_rdata),  32'hBEEF);
    chk("rd1_err",     32'(rsp_err),    32'd0);
    chk("rd1_ack",     32'({Ack, RRq}), 32'b10);
    chk("rd1_addr",    32'(addr_at_rrq), 32'h00010);
    @(negedge clk);
    chk("rd1_pulse",   32'({rsp_valid, Ack}), 32'd0);

    // Write 0xA5A5 to 0xFFFFF; rsp_rdata must not change.
    issue(1'b1, 20'hFFFFF, 16'hA5A5);
    wait_rsp(50, found, lat);
    chk("wr_found",    32'(found),     32'd1);
    chk("wr_latency",  32'(lat),       32'd7);
    chk("wr_data_bus", 32'(wr_seen),   32'hA5A5);
    chk("wr_rdata_kept", 32'(rsp_rdata), 32'hBEEF);

    // Reads after the write: a lingering write drive would corrupt 0xBEEF.
    issue(1'b0, 20'h00010, '0);
    wait_rsp(50, found, lat);
    chk("rd2_rdata", 32'(rsp_rdata), 32'hBEEF);
    issue(1'b0, 20'hFFFFF, '0);
    wait_rsp(50, found, lat);
    chk("rd3_rdata", 32'(rsp_rdata), 32'hA5A5);

    // Back-to-back reads, req_valid held high, OK left high between accesses.
    ok_drop = 1'b0;
    a0 = acc_cnt;
    r0 = rsp_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h00010;
    n = 0;
    while (acc_cnt != a0 + 1 && n < 50) begin @(posedge clk); #1; n++; end
    t1 = last_acc_cyc;
    req_addr = 20'hFFFFF;
    wait_rsp(50, found, lat);
    chk("b2b1_latency", 32'(lat),       32'd7);
    chk("b2b1_rdata",   32'(rsp_rdata), 32'hBEEF);
    n = 0;
    while (acc_cnt != a0 + 2 && n < 50) begin @(posedge clk); #1; n++; end
    req_valid = 1'b0;
    chk("b2b_accept_gap", 32'(last_acc_cyc - t1), 32'd11);
    wait_rsp(50, found, lat);
    chk("b2b2_latency",  32'(lat),       32'd7);
    chk("b2b2_no_early", 32'((cyc - rrq_rise_cyc) >= 5), 32'd1);
    chk("b2b2_rdata",    32'(rsp_rdata), 32'hA5A5);
    repeat (12) @(posedge clk);
    chk("b2b_rsp_count", 32'(rsp_cnt - r0), 32'd2);
    ok_drop = 1'b1;

    // Memory never answers.
    mem_en = 1'b0;
    repeat (3) @(posedge clk);
    issue(1'b0, 20'h00010, '0);
`ifdef ASYNCMEM_TIMEOUT_EN
    wait_rsp(400, found, lat);
    chk("tmo_found",   32'(found),     32'd1);
    chk("tmo_latency", 32'(lat),       32'd261);
    chk("tmo_err",     32'(rsp_err),   32'd1);
    chk("tmo_rdata",   32'(rsp_rdata), 32'hA5A5);
    issue(1'b0, 20'h00010, '0);
    repeat (20) @(posedge clk);
`else
    wait_rsp(1000, found, lat);
    chk("no_tmo_rsp", 32'(found),   32'd0);
    chk("no_tmo_err", 32'(rsp_err), 32'd0);
`endif

    // Asynchronous reset while stuck in WAIT_OK.
    @(posedge clk); #1;
    chk("pre_rst_rrq", 32'(RRq), 32'd1);
    r0 = rsp_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", 32'({RRq, WRq, Ack}), 32'd0);
    chk("mid_rst_ready",   32'(req_ready),        32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready),     32'd1);
    chk("post_rst_nrsp",  32'(rsp_cnt - r0),  32'd0);
    chk("strobes_exclusive", 32'(both_strobe), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
